// File: rtl/lc3_imem_responder.sv
// Pipelined LC3 instruction memory with a preload port; outputs land RD_LATENCY-1 edges after the accept edge.
// Optional macro IMEM_PARITY_EN stores an even-parity bit per word and reports read mismatches on parity_err.
module lc3_imem_responder #(
  parameter int          ADDR_W     = 8,
  parameter int          RD_LATENCY = 1,
  parameter logic [15:0] OOR_WORD   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  input  logic        load_par_flip,
  output logic [15:0] instr_dout,
  output logic        instr_valid,
  output logic        addr_err,
  output logic        parity_err
);

  typedef struct packed {
    logic        vld;
    logic        oor;
    logic        perr;
    logic [15:0] dat;
  } stage_t;

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("lc3_imem_responder: RD_LATENCY must be in 1..4");
    end
  endgenerate

`ifdef IMEM_PARITY_EN
  localparam int WORD_W = 17;
`else
  localparam int WORD_W = 16;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              rd_oor;
  logic              load_ok;
  stage_t            in_stg;
  stage_t            pipe [RD_LATENCY];

  assign rd_oor  = (pc >> ADDR_W) != 16'd0;
  assign load_ok = load_en && ((load_addr >> ADDR_W) == 16'd0);
  assign rd_word = mem[pc[ADDR_W-1:0]];

`ifdef IMEM_PARITY_EN
  assign wr_word = {(^load_data) ^ load_par_flip, load_data};
`else
  logic unused_par_flip;
  assign wr_word         = load_data;
  assign unused_par_flip = load_par_flip;
`endif

  // Array is read combinationally at the accept edge, so a same-edge load is seen only by later reads.
  always_ff @(posedge clock) begin
    if (!reset && load_ok) begin
      mem[load_addr[ADDR_W-1:0]] <= wr_word;
    end
  end

  always_comb begin
    in_stg = '0;
    if (instrmem_rd) begin
      in_stg.vld = 1'b1;
      in_stg.oor = rd_oor;
      if (rd_oor) begin
        in_stg.dat = OOR_WORD;
      end else begin
        in_stg.dat = rd_word[15:0];
`ifdef IMEM_PARITY_EN
        in_stg.perr = ^rd_word;
`endif
      end
    end
  end

  // Data only advances alongside a valid so the last stage holds the previous word through gaps.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].vld  <= in_stg.vld;
      pipe[0].oor  <= in_stg.oor;
      pipe[0].perr <= in_stg.perr;
      if (in_stg.vld) begin
        pipe[0].dat <= in_stg.dat;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i].vld  <= pipe[i-1].vld;
        pipe[i].oor  <= pipe[i-1].oor;
        pipe[i].perr <= pipe[i-1].perr;
        if (pipe[i-1].vld) begin
          pipe[i].dat <= pipe[i-1].dat;
        end
      end
    end
  end

  assign instr_dout  = pipe[RD_LATENCY-1].dat;
  assign instr_valid = pipe[RD_LATENCY-1].vld;
  assign addr_err    = pipe[RD_LATENCY-1].oor;
  assign parity_err  = pipe[RD_LATENCY-1].perr;

endmodule
